// File: rtl/attitude_pkg.sv
// Shared definitions for the attitude estimation pipeline: data width,
// tilt-filter FSM states, default gains and the 16-bit saturator.
package attitude_pkg;

  localparam int unsigned DATA_W = 16;

  localparam int unsigned                    DEF_DT_SHIFT    = 7;
  localparam int unsigned                    DEF_ALPHA_SHIFT = 5;
  localparam logic signed [DATA_W-1:0]       DEF_Z_MIN       = 16'sd1024;

  typedef enum logic [2:0] {
    IDLE,
    INT_R,
    BLEND_R,
    INT_P,
    BLEND_P
  } tilt_state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W+1:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/comp_axis_datapath.sv
// Combinational integrate/blend unit shared by the roll and pitch axes.
// i_blend=0: gyro integration of i_angle; i_blend=1: accel pull of i_angle (the prediction).
module comp_axis_datapath
  import attitude_pkg::*;
#(
  parameter int unsigned DT_SHIFT    = DEF_DT_SHIFT,
  parameter int unsigned ALPHA_SHIFT = DEF_ALPHA_SHIFT
) (
  input  logic signed [DATA_W-1:0] i_angle,
  input  logic signed [DATA_W-1:0] i_rate,
  input  logic signed [DATA_W-1:0] i_ref,
  input  logic                     i_acc_ok,
  input  logic                     i_blend,
  output logic signed [DATA_W-1:0] o_next
);

  logic signed [DATA_W+1:0] w_angle_ext;
  logic signed [DATA_W+1:0] w_rate_ext;
  logic signed [DATA_W+1:0] w_ref_ext;
  logic signed [DATA_W+1:0] w_sum;
  logic signed [DATA_W+1:0] w_err;
  logic signed [DATA_W+1:0] w_pull;

  assign w_angle_ext = $signed({{2{i_angle[DATA_W-1]}}, i_angle});
  assign w_rate_ext  = $signed({{2{i_rate[DATA_W-1]}},  i_rate});
  assign w_ref_ext   = $signed({{2{i_ref[DATA_W-1]}},   i_ref});

  // 18 bits hold every intermediate exactly, so only the final result is clamped
  assign w_sum  = w_angle_ext + (w_rate_ext >>> DT_SHIFT);
  assign w_err  = w_angle_ext - w_ref_ext;
  assign w_pull = w_angle_ext - (w_err >>> ALPHA_SHIFT);

  always_comb begin
    o_next = sat16(w_sum);
    if (i_blend) begin
      o_next = i_acc_ok ? sat16(w_pull) : i_angle;
    end
  end

endmodule

// File: rtl/comp_filter_tilt.sv
// Complementary-filter tilt estimator: one shared integrate/blend datapath
// sequenced over roll then pitch for every accepted sample set.
module comp_filter_tilt
  import attitude_pkg::*;
#(
  parameter int unsigned              DT_SHIFT    = DEF_DT_SHIFT,
  parameter int unsigned              ALPHA_SHIFT = DEF_ALPHA_SHIFT,
  parameter logic signed [DATA_W-1:0] Z_MIN       = DEF_Z_MIN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] gyro_x,
  input  logic signed [DATA_W-1:0] gyro_y,
  input  logic signed [DATA_W-1:0] accl_x,
  input  logic signed [DATA_W-1:0] accl_y,
  input  logic signed [DATA_W-1:0] accl_z,
  output logic signed [DATA_W-1:0] roll,
  output logic signed [DATA_W-1:0] pitch,
  output logic                     angle_valid,
  output logic                     busy,
  output logic                     overrun
);

  tilt_state_t              r_state;
  logic signed [DATA_W-1:0] r_gx, r_gy, r_ax, r_ay;
  logic                     r_acc_ok;
  logic signed [DATA_W-1:0] r_pred;
  logic signed [DATA_W-1:0] r_roll, r_pitch;
  logic                     r_angle_valid, r_busy, r_overrun;

  logic signed [DATA_W-1:0] w_pitch_ref;
  logic signed [DATA_W-1:0] w_angle, w_rate, w_ref, w_next;
  logic                     w_blend;

  // Pitch reference is -accl_x; negating -32768 must clamp, not wrap
  assign w_pitch_ref = sat16(-$signed({{2{r_ax[DATA_W-1]}}, r_ax}));

  always_comb begin
    w_angle = r_pred;
    w_rate  = r_gx;
    w_ref   = r_ay;
    w_blend = 1'b0;
    case (r_state)
      INT_R: begin
        w_angle = r_roll;
        w_rate  = r_gx;
      end
      INT_P: begin
        w_angle = r_pitch;
        w_rate  = r_gy;
      end
      BLEND_R: begin
        w_blend = 1'b1;
        w_ref   = r_ay;
      end
      BLEND_P: begin
        w_blend = 1'b1;
        w_ref   = w_pitch_ref;
      end
      default: ;
    endcase
  end

  comp_axis_datapath #(
    .DT_SHIFT   (DT_SHIFT),
    .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_axis (
    .i_angle (w_angle),
    .i_rate  (w_rate),
    .i_ref   (w_ref),
    .i_acc_ok(r_acc_ok),
    .i_blend (w_blend),
    .o_next  (w_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_gx          <= '0;
      r_gy          <= '0;
      r_ax          <= '0;
      r_ay          <= '0;
      r_acc_ok      <= 1'b0;
      r_pred        <= '0;
      r_roll        <= '0;
      r_pitch       <= '0;
      r_angle_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_angle_valid <= 1'b0;
      r_overrun     <= sample_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_gx     <= gyro_x;
            r_gy     <= gyro_y;
            r_ax     <= accl_x;
            r_ay     <= accl_y;
            r_acc_ok <= (accl_z >= Z_MIN);
            r_busy   <= 1'b1;
            r_state  <= INT_R;
          end
        end
        INT_R: begin
          r_pred  <= w_next;
          r_state <= BLEND_R;
        end
        BLEND_R: begin
          r_roll  <= w_next;
          r_state <= INT_P;
        end
        INT_P: begin
          r_pred  <= w_next;
          r_state <= BLEND_P;
        end
        BLEND_P: begin
          r_pitch       <= w_next;
          r_angle_valid <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign roll        = r_roll;
  assign pitch       = r_pitch;
  assign angle_valid = r_angle_valid;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule
